// File: rtl/ddfs_tuning_word_bank.sv
// ddfs_tuning_word_bank
// ---------------------
// Multi-channel, double-buffered tuning-word bank for the DDFS datapath.
// The host writes per-channel shadow words at any time. A commit moves every
// pending shadow word to its active word in one clock edge. The move happens
// either immediately or on the next phase-accumulator Sync pulse. If no Sync
// arrives within TIMEOUT cycles, the move is forced.
//
// Optional feature (macro DDFS_GLIDE_EN): with GlideEn=1 and GlideStep!=0,
// the active words ramp toward their new values by GlideStep per cycle.
// They stop exactly on the target and never overshoot.
//
// Parameters:
//   WIDTH    tuning-word width in bits
//   CHANNELS number of channels (1..16)
//   CH_BITS  channel-select width, 2**CH_BITS >= CHANNELS
//   TIMEOUT  cycles to wait in ARMED before a forced transfer (>= 2)
//   TMR_BITS timer width, 2**TMR_BITS >= TIMEOUT
//
// Ports:
//   Clock     rising-edge clock
//   Reset     synchronous, active-low reset
//   WrEN      shadow write strobe
//   WrCh      shadow write channel (values >= CHANNELS are ignored)
//   WrData    shadow write data
//   Commit    transfer request pulse (ignored while Busy)
//   SyncMode  sampled with Commit: 1 = wait for Sync, 0 = immediate
//   Sync      phase-alignment pulse
//   GlideEn   (DDFS_GLIDE_EN only) ramp instead of jump
//   GlideStep (DDFS_GLIDE_EN only) ramp increment per cycle
//   Dout      active words, channel i at [i*WIDTH +: WIDTH]
//   Pending   per-channel "shadow not yet committed"
//   Busy      FSM not in IDLE
//   Done      one-cycle pulse after a transfer completes
//   TimedOut  sticky, last transfer was forced by timeout
//
// Handshake: Commit is accepted only on an edge where the FSM is in IDLE,
// which is the case when Busy is 0. Commits seen while Busy is 1 are
// dropped; nothing is queued.
module ddfs_tuning_word_bank #(
  parameter int WIDTH    = 48,
  parameter int CHANNELS = 4,
  parameter int CH_BITS  = 2,
  parameter int TIMEOUT  = 1024,
  parameter int TMR_BITS = 10
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      WrEN,
  input  logic [CH_BITS-1:0]        WrCh,
  input  logic [WIDTH-1:0]          WrData,
  input  logic                      Commit,
  input  logic                      SyncMode,
  input  logic                      Sync,
`ifdef DDFS_GLIDE_EN
  input  logic                      GlideEn,
  input  logic [WIDTH-1:0]          GlideStep,
`endif
  output logic [CHANNELS*WIDTH-1:0] Dout,
  output logic [CHANNELS-1:0]       Pending,
  output logic                      Busy,
  output logic                      Done,
  output logic                      TimedOut
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    XFER  = 2'd2
`ifdef DDFS_GLIDE_EN
    , GLIDE = 2'd3
`endif
  } state_t;

  state_t                state, state_next;
  logic [TMR_BITS-1:0]   timer, timer_next;
  logic                  timed_out_next;
  logic                  done_next;
  logic                  xfer;
  logic [CHANNELS-1:0]   wr_hit;
  logic [CHANNELS-1:0]   clr_mask;
  logic [CHANNELS-1:0]   pending_next;

  logic [WIDTH-1:0]      shadow [CHANNELS];
  logic [WIDTH-1:0]      active [CHANNELS];

`ifdef DDFS_GLIDE_EN
  logic                  glide_start;
  logic                  glide_run;
  logic                  all_reached;
  logic [WIDTH-1:0]      target     [CHANNELS];
  logic [WIDTH-1:0]      glide_next [CHANNELS];
`endif

  // Decode the write channel. Out-of-range channels match no bit.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit[i] = WrEN && (WrCh == CH_BITS'(i));
    end
  end

`ifdef DDFS_GLIDE_EN
  // Next ramp value per channel. Each step is clamped to the remaining
  // distance, so the word can never overshoot or wrap.
  always_comb begin
    all_reached = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      glide_next[i] = active[i];
      if (active[i] < target[i]) begin
        glide_next[i] = ((target[i] - active[i]) <= GlideStep) ? target[i]
                                                               : active[i] + GlideStep;
      end else if (active[i] > target[i]) begin
        glide_next[i] = ((active[i] - target[i]) <= GlideStep) ? target[i]
                                                               : active[i] - GlideStep;
      end
      if (active[i] != target[i]) all_reached = 1'b0;
    end
  end
`endif

  always_comb begin
    state_next     = state;
    timer_next     = timer;
    timed_out_next = TimedOut;
    done_next      = 1'b0;
    xfer           = 1'b0;
`ifdef DDFS_GLIDE_EN
    glide_start    = 1'b0;
    glide_run      = 1'b0;
`endif
    case (state)
      IDLE: begin
        // A Sync on the same edge as Commit is not used; ARMED waits for
        // the next Sync.
        if (Commit) begin
          timed_out_next = 1'b0;
          if (SyncMode) begin
            state_next = ARMED;
            timer_next = '0;
          end else begin
            state_next = XFER;
          end
        end
      end
      ARMED: begin
        if (Sync) begin
          state_next = XFER;
        end else if (timer == TMR_BITS'(TIMEOUT - 1)) begin
          state_next     = XFER;
          timed_out_next = 1'b1;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      XFER: begin
`ifdef DDFS_GLIDE_EN
        if (GlideEn && (GlideStep != '0)) begin
          glide_start = 1'b1;
          state_next  = GLIDE;
        end else begin
          xfer       = 1'b1;
          done_next  = 1'b1;
          state_next = IDLE;
        end
`else
        xfer       = 1'b1;
        done_next  = 1'b1;
        state_next = IDLE;
`endif
      end
`ifdef DDFS_GLIDE_EN
      GLIDE: begin
        if (all_reached) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          glide_run = 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Pending bits consumed by this transfer clear. A write on the same edge
  // sets its bit again, so the new data waits for the next commit.
  always_comb begin
    clr_mask = '0;
`ifdef DDFS_GLIDE_EN
    if (xfer || glide_start) clr_mask = Pending;
`else
    if (xfer) clr_mask = Pending;
`endif
    pending_next = (Pending & ~clr_mask) | wr_hit;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state    <= IDLE;
      timer    <= '0;
      Pending  <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      TimedOut <= 1'b0;
    end else begin
      state    <= state_next;
      timer    <= timer_next;
      Pending  <= pending_next;
      Busy     <= (state_next != IDLE);
      Done     <= done_next;
      TimedOut <= timed_out_next;
    end
  end

  // Word storage. The transfer reads the shadow value from before this
  // edge, so a simultaneous write does not leak into the active word.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
`ifdef DDFS_GLIDE_EN
        target[i] <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_hit[i]) shadow[i] <= WrData;
        if (xfer && Pending[i]) active[i] <= shadow[i];
`ifdef DDFS_GLIDE_EN
        if (glide_start) target[i] <= Pending[i] ? shadow[i] : active[i];
        if (glide_run) active[i] <= glide_next[i];
`endif
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_dout
    assign Dout[g*WIDTH +: WIDTH] = active[g];
  end

endmodule

// File: tb/tb_ddfs_tuning_word_bank.sv
// Directed testbench for ddfs_tuning_word_bank.
// Inputs change on the falling edge. Outputs are checked on the falling edge
// after the rising edge that samples them.
module tb_ddfs_tuning_word_bank;
  localparam int W  = 48;
  localparam int CH = 4;
  localparam int CB = 3;

  logic              clock;
  logic              reset;
  logic              wr_en;
  logic [CB-1:0]     wr_ch;
  logic [W-1:0]      wr_data;
  logic              commit;
  logic              sync_mode;
  logic              sync;
  logic [CH*W-1:0]   dout;
  logic [CH-1:0]     pending;
  logic              busy;
  logic              done;
  logic              timed_out;
`ifdef DDFS_GLIDE_EN
  logic              glide_en;
  logic [W-1:0]      glide_step;
`endif

  int checks = 0;
  int errors = 0;
  logic [CH*W-1:0] exp_dout;

  ddfs_tuning_word_bank #(
    .WIDTH(W), .CHANNELS(CH), .CH_BITS(CB), .TIMEOUT(8), .TMR_BITS(3)
  ) dut (
    .Clock(clock), .Reset(reset), .WrEN(wr_en), .WrCh(wr_ch), .WrData(wr_data),
    .Commit(commit), .SyncMode(sync_mode), .Sync(sync),
`ifdef DDFS_GLIDE_EN
    .GlideEn(glide_en), .GlideStep(glide_step),
`endif
    .Dout(dout), .Pending(pending), .Busy(busy), .Done(done), .TimedOut(timed_out)
  );

  // clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write(input int ch, input logic [W-1:0] data);
    wr_en = 1'b1; wr_ch = CB'(ch); wr_data = data;
    step();
    wr_en = 1'b0;
  endtask

  task automatic set_exp(input int ch, input logic [W-1:0] data);
    exp_dout[ch*W +: W] = data;
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
    commit = 1'b0; sync_mode = 1'b0; sync = 1'b0;
`ifdef DDFS_GLIDE_EN
    glide_en = 1'b0; glide_step = '0;
`endif
    exp_dout = '0;
    @(negedge clock);
    step(); step();
    reset = 1'b1;

    // reset state
    chk("rst_dout", dout, '0);
    chk("rst_pending", pending, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_timedout", timed_out, 1'b0);

    // immediate commit of channel 2
    write(2, 48'h0000_1234_5678);
    chk("t1_pending", pending, 4'b0100);
    chk("t1_dout_before", dout, exp_dout);
    commit = 1'b1; sync_mode = 1'b0;
    step();
    commit = 1'b0;
    chk("t1_busy", busy, 1'b1);
    chk("t1_done_early", done, 1'b0);
    chk("t1_dout_hold", dout, exp_dout);
    step();
    set_exp(2, 48'h0000_1234_5678);
    chk("t1_dout", dout, exp_dout);
    chk("t1_done", done, 1'b1);
    chk("t1_busy_off", busy, 1'b0);
    chk("t1_pending_clr", pending, 4'b0000);
    step();
    chk("t1_done_once", done, 1'b0);

    // synced commit of channel 0, Sync after 5 cycles
    write(0, 48'h10);
    commit = 1'b1; sync_mode = 1'b1;
    step();
    commit = 1'b0; sync_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_busy_wait", busy, 1'b1);
      chk("t2_dout_wait", dout, exp_dout);
    end
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("t2_busy_xfer", busy, 1'b1);
    chk("t2_dout_hold", dout, exp_dout);
    step();
    set_exp(0, 48'h10);
    chk("t2_dout", dout, exp_dout);
    chk("t2_done", done, 1'b1);
    chk("t2_timedout", timed_out, 1'b0);

    // timeout: TIMEOUT=8, no Sync
    write(3, 48'hABC);
    commit = 1'b1; sync_mode = 1'b1;
    step();
    commit = 1'b0; sync_mode = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("t3_armed_busy", busy, 1'b1);
      chk("t3_armed_to", timed_out, 1'b0);
    end
    step();
    chk("t3_to_set", timed_out, 1'b1);
    chk("t3_no_done", done, 1'b0);
    chk("t3_dout_hold", dout, exp_dout);
    step();
    set_exp(3, 48'hABC);
    chk("t3_dout", dout, exp_dout);
    chk("t3_done", done, 1'b1);
    chk("t3_busy_off", busy, 1'b0);
    step(); step();
    chk("t3_to_sticky", timed_out, 1'b1);

    // write on the XFER edge
    write(1, 48'h5);
    commit = 1'b1; sync_mode = 1'b0;
    step();
    commit = 1'b0;
    chk("t4_to_clr", timed_out, 1'b0);
    write(1, 48'hA);
    set_exp(1, 48'h5);
    chk("t4_dout_old", dout, exp_dout);
    chk("t4_pending_kept", pending, 4'b0010);
    chk("t4_done", done, 1'b1);
    commit = 1'b1;
    step();
    commit = 1'b0;
    step();
    set_exp(1, 48'hA);
    chk("t4_dout_new", dout, exp_dout);
    chk("t4_pending_clr", pending, 4'b0000);

    // out-of-range channel, commit while busy
    write(5, 48'hFFFF_FFFF_FFFF);
    chk("t5_pending_oor", pending, 4'b0000);
    chk("t5_dout_oor", dout, exp_dout);
    commit = 1'b1; sync_mode = 1'b1;
    step();
    sync_mode = 1'b0;
    step();
    commit = 1'b0;
    chk("t5_still_armed", busy, 1'b1);
    chk("t5_no_done", done, 1'b0);
    sync = 1'b1;
    step();
    sync = 1'b0;
    step();
    chk("t5_done", done, 1'b1);
    chk("t5_dout_same", dout, exp_dout);
    step();
    chk("t5_no_second_done", done, 1'b0);
    chk("t5_idle", busy, 1'b0);

    // Commit and Sync together in IDLE: Sync is not used
    write(0, 48'h22);
    commit = 1'b1; sync_mode = 1'b1; sync = 1'b1;
    step();
    commit = 1'b0; sync_mode = 1'b0; sync = 1'b0;
    step();
    chk("t6_wait_busy", busy, 1'b1);
    chk("t6_wait_dout", dout, exp_dout);
    sync = 1'b1;
    step();
    sync = 1'b0;
    step();
    set_exp(0, 48'h22);
    chk("t6_dout", dout, exp_dout);

    // reset mid-operation aborts with no partial update
    write(2, 48'h77);
    commit = 1'b1; sync_mode = 1'b0;
    step();
    commit = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    exp_dout = '0;
    chk("t7_dout", dout, exp_dout);
    chk("t7_pending", pending, 4'b0000);
    chk("t7_busy", busy, 1'b0);
    step();
    chk("t7_no_done", done, 1'b0);
    chk("t7_dout_after", dout, exp_dout);

`ifdef DDFS_GLIDE_EN
    // glide from 100 to 130 in steps of 12
    write(0, 48'd100);
    commit = 1'b1;
    step();
    commit = 1'b0;
    step();
    set_exp(0, 48'd100);
    chk("g_start", dout, exp_dout);
    write(0, 48'd130);
    glide_en = 1'b1; glide_step = 48'd12;
    commit = 1'b1;
    step();
    commit = 1'b0;
    step();
    chk("g_enter", dout, exp_dout);
    chk("g_enter_done", done, 1'b0);
    step(); set_exp(0, 48'd112); chk("g_112", dout, exp_dout);
    step(); set_exp(0, 48'd124); chk("g_124", dout, exp_dout);
    step(); set_exp(0, 48'd130); chk("g_130", dout, exp_dout);
    chk("g_no_done_yet", done, 1'b0);
    step();
    chk("g_done", done, 1'b1);
    chk("g_dout_final", dout, exp_dout);
    step();
    chk("g_done_once", done, 1'b0);
    glide_en = 1'b0; glide_step = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ddfs_tuning_word_bank.md
Name: ddfs_tuning_word_bank

Overview:
- Multi-channel, double-buffered tuning-word register bank for the DDFS datapath; successor to the single 48-bit load-enable register.
- Host writes per-channel shadow words at any time; a commit handshake moves all pending shadows to the active outputs atomically.
- The move is immediate or aligned to a phase-accumulator sync pulse, with a timeout fallback.
- Active words feed the phase accumulators directly.

Parameters:
- WIDTH, 48, tuning-word width in bits.
- CHANNELS, 4, number of channels (1..16).
- CH_BITS, 2, channel-select width; 2**CH_BITS >= CHANNELS.
- TIMEOUT, 1024, cycles to wait for Sync in ARMED before a forced transfer (>= 2).
- TMR_BITS, 10, timer width; 2**TMR_BITS >= TIMEOUT.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  reset, synchronous, active-low.
- WrEN  in  1  shadow write strobe.
- WrCh  in  CH_BITS  shadow write channel.
- WrData  in  WIDTH  shadow write data.
- Commit  in  1  transfer request pulse.
- SyncMode  in  1  sampled with Commit: 1 = wait for Sync, 0 = immediate.
- Sync  in  1  phase-alignment pulse (e.g. accumulator wrap).
- Dout  out  CHANNELS*WIDTH  active words; channel i at [i*WIDTH +: WIDTH].
- Pending  out  CHANNELS  per-channel "shadow not yet committed".
- Busy  out  1  state != IDLE.
- Done  out  1  one-cycle pulse after a transfer completes.
- TimedOut  out  1  sticky; last transfer was forced by timeout.

Behaviour:
- Reset low at a rising edge:
  - all shadow and active words = 0, Pending = 0, state = IDLE, timer = 0.
  - Busy = 0, Done = 0, TimedOut = 0.
  - Reset mid-operation aborts any transfer; no partial update.
- All outputs are registered.
- Write:
  - WrEN=1 with WrCh < CHANNELS sets shadow[WrCh] <= WrData and Pending[WrCh] <= 1.
  - WrCh >= CHANNELS is ignored.
  - Writes are accepted in every state.
- FSM states are IDLE, ARMED, XFER, plus GLIDE when the optional feature is enabled.
- IDLE:
  - Commit=1 with SyncMode=0 goes to XFER.
  - Commit=1 with SyncMode=1 goes to ARMED, with timer <= 0 and TimedOut <= 0.
  - Commit=0 stays in IDLE.
  - An accepted Commit also clears TimedOut.
- ARMED:
  - Sync=1 goes to XFER.
  - Otherwise timer increments; when timer == TIMEOUT-1 and Sync=0, go to XFER and set TimedOut <= 1.
- XFER (one edge):
  - For every i with Pending[i]=1: active[i] <= shadow[i], Pending[i] <= 0.
  - Done <= 1 for exactly one cycle; next state is IDLE.
- Commit while Busy=1 is ignored (no queuing).
- Commit with Pending = 0 still runs the FSM and pulses Done; Dout is unchanged.
- Write on the same edge as XFER:
  - the transfer uses the pre-write shadow value;
  - that channel's Pending stays 1 and its new data waits for the next commit.
- Latency:
  - SyncMode=0: Commit sampled at edge k gives Dout updated at edge k+1 and Done high from k+1 to k+2; Busy high from k to k+1.
  - SyncMode=1: Sync sampled at edge m gives Dout updated at edge m+1.
- Commit and Sync on the same edge in IDLE: Sync is not used; the FSM enters ARMED and waits for the next Sync.

Optional Feature:
- Macro: DDFS_GLIDE_EN.
- When defined, adds inputs GlideEn (1) and GlideStep (WIDTH).
- In XFER with GlideEn=1 and GlideStep != 0:
  - targets are captured from the pending shadows and Pending bits clear;
  - state goes to GLIDE, and Done is not pulsed yet.
- In GLIDE, each active word moves one GlideStep per cycle toward its target:
  - unsigned compare;
  - clamp at the target, never overshoot;
  - no wrap-around.
- When all channels equal their targets: Done pulses and the FSM returns to IDLE.
- Writes during GLIDE update shadow only.
- Reset during GLIDE zeroes everything.
- When not defined: the ports are absent and XFER always updates immediately.

Test Plan:
- Reset, then write ch2=48'h0000_1234_5678, Commit with SyncMode=0 -> Pending=4'b0100 after write; Dout ch2=48'h0000_1234_5678 one edge after Commit; Done 1 cycle; Pending=0; other channels 0.
- Write ch0=48'h10, Commit with SyncMode=1, Sync after 5 cycles -> Busy=1 throughout, Dout ch0 stays 0 until the edge after Sync, then 48'h10; TimedOut=0.
- TIMEOUT=8, Commit with SyncMode=1, no Sync -> forced transfer after 8 ARMED cycles; TimedOut=1 and stays 1 until the next accepted Commit.
- Write ch1=48'hA on the same edge as XFER, with a pending older value 48'h5 -> Dout ch1=48'h5, Pending[1]=1; the next commit yields 48'hA.
- WrCh=5 with CHANNELS=4, and Commit while Busy -> no state change; no second Done.
- With DDFS_GLIDE_EN: active ch0=100, target 130, GlideStep=12 -> ch0 goes 112, 124, 130, then Done pulses once.
